lpddr2_avl_arbiter: RTL and testbench
=====================================

# lpddr2_avl_arbiter

Two-port round-robin arbiter that shares the single LPDDR2 controller Avalon-MM port (27-bit word address, 32-bit data, burstcount 1) between two requesters. It sits between the system masters and the memory controller. It holds off all traffic until calibration succeeds, registers each accepted command and issues it to the controller. A tag FIFO routes every read return back to the requester that issued it.

## Interface
Parameters:
- ADDR_W, 27, word address width
- DATA_W, 32, data width
- BE_W, 4, byteenable width (DATA_W/8)
- MAX_OUTSTANDING, 8, read tag FIFO depth, power of two, at least 2

Ports:
- clk_clk  in  1  sole clock; all logic rising-edge
- reset_reset  in  1  synchronous, active-high reset
- mN_address  in  ADDR_W  requester N (N = 0,1) word address
- mN_read / mN_write  in  1  requester N command strobes
- mN_writedata  in  DATA_W; mN_byteenable  in  BE_W
- mN_waitrequest  out  1  active-high; command accepted at an edge where strobe=1 and waitrequest=0
- mN_readdata  out  DATA_W; mN_readdatavalid  out  1
- avl_address  out  ADDR_W; avl_writedata  out  DATA_W; avl_byteenable  out  BE_W
- avl_read / avl_write / avl_beginbursttransfer  out  1
- avl_burstcount  out  1  constant 1
- avl_waitrequest_n  in  1  controller ready, active-high
- avl_readdatavalid  in  1; avl_readdata  in  DATA_W
- local_init_done / local_cal_success / local_cal_fail  in  1  controller status
- mem_ready  out  1  high when in IDLE or ISSUE
- rd_err  out  1  sticky: readdatavalid arrived with the tag FIFO empty

## Operation
- FSM has three states: INIT, IDLE and ISSUE. Reset enters INIT.
- INIT -> IDLE when local_init_done && local_cal_success && !local_cal_fail. If local_cal_fail is ever seen, the FSM stays in INIT until reset.
- Eligibility: port N is eligible when mN_write=1, or when mN_read=1 and tag count < MAX_OUTSTANDING.
- Grant is issued in IDLE only. Both ports eligible: grant goes to the port not granted last (last_grant resets to 1, so port 0 wins first). One port eligible: that port is granted.
- mN_waitrequest = !(state==IDLE && grant==N), combinational. It is 1 in all other cases.
- Acceptance latches address, writedata, byteenable and the op into the command register, sets last_grant = N, and moves to ISSUE.
- A requester asserting read and write together is treated as a write; the read is dropped.
- ISSUE drives avl_read or avl_write from the command register and holds all avl_* signals stable until an edge with avl_waitrequest_n=1.
- avl_beginbursttransfer = 1 only in the first ISSUE cycle of each command.
- On completion of a read, N is pushed into the tag FIFO. The FSM then returns to IDLE.
- Read return: on avl_readdatavalid, pop the FIFO head T. Register avl_readdata into mT_readdata and pulse mT_readdatavalid for one cycle. The other port's readdatavalid stays 0. readdata holds its last value otherwise.
- Push and pop in the same cycle leave the count unchanged.
- readdatavalid with an empty FIFO sets rd_err and the data is dropped.
- Reset in any state: FSM to INIT, FIFO count 0, command dropped, all outputs to reset values.

## Timing
- Reset values: mN_waitrequest=1, mN_readdatavalid=0, mN_readdata=0, avl_read/write/beginbursttransfer=0, avl_address/writedata/byteenable=0, mem_ready=0, rd_err=0.
- Accept edge at cycle k -> avl_* command valid from cycle k+1.
- If avl_waitrequest_n=1 in cycle k+1, the FSM is back in IDLE at k+2, and the next accept can occur at edge k+2.
- Peak throughput is one command per 2 cycles.
- Read data latency is exactly 1 cycle: avl_readdatavalid at cycle m -> mT_readdatavalid at cycle m+1.
- Return order equals issue order across both ports.

## Test plan
- Gating: hold local_cal_success=0 for 20 cycles with m0_write=1 -> m0_waitrequest stays 1 and avl_write=0. Raise local_cal_success -> accepted within 2 cycles. Pulse local_cal_fail=1 after reset -> mem_ready stays 0 forever.
- Single write: m0 writes address 0x1234567, data 0xDEADBEEF, byteenable 0xF with avl_waitrequest_n=1 -> one cycle of avl_write with those values, beginbursttransfer=1, burstcount=1.
- Fairness: both ports continuously issue writes -> grants alternate 0,1,0,1… with port 0 first.
- Routing: m0 reads A, m1 reads B, m0 reads C. Controller returns 0x1,0x2,0x3 -> m0 gets 0x1 then 0x3, m1 gets 0x2, each 1 cycle after avl_readdatavalid.
- Backpressure and full: hold avl_waitrequest_n=0 for 5 cycles during ISSUE -> avl_* are stable, then complete. Issue 8 reads from m1 with no returns -> the 9th read stalls while an m0 write is still granted. One return unblocks the 9th read.
- Errors and reset: avl_readdatavalid with FIFO empty -> rd_err=1 until reset. Assert reset_reset in ISSUE -> the next cycle shows avl_read=0 and state INIT.

Source files
------------

// File: rtl/lpddr2_avl_arbiter.sv
// Two-port round-robin arbiter in front of a single LPDDR2 Avalon-MM controller port.
// Traffic is held off until calibration succeeds; a tag FIFO steers read returns.
module lpddr2_avl_arbiter #(
  parameter int ADDR_W          = 27,
  parameter int DATA_W          = 32,
  parameter int BE_W            = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] avl_address,
  output logic [DATA_W-1:0] avl_writedata,
  output logic [BE_W-1:0]   avl_byteenable,
  output logic              avl_read,
  output logic              avl_write,
  output logic              avl_beginbursttransfer,
  output logic              avl_burstcount,
  input  logic              avl_waitrequest_n,
  input  logic              avl_readdatavalid,
  input  logic [DATA_W-1:0] avl_readdata,
  input  logic              local_init_done,
  input  logic              local_cal_success,
  input  logic              local_cal_fail,
  output logic              mem_ready,
  output logic              rd_err
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 cal_fail_q, cal_fail_d;
  logic                 last_grant_q, last_grant_d;
  logic                 cmd_port_q, cmd_port_d;
  logic [ADDR_W-1:0]    avl_address_q, avl_address_d;
  logic [DATA_W-1:0]    avl_writedata_q, avl_writedata_d;
  logic [BE_W-1:0]      avl_byteenable_q, avl_byteenable_d;
  logic                 avl_read_q, avl_read_d;
  logic                 avl_write_q, avl_write_d;
  logic                 avl_bbt_q, avl_bbt_d;
  logic [MAX_OUTSTANDING-1:0] tag_q, tag_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_W-1:0]    m0_readdata_q, m0_readdata_d;
  logic [DATA_W-1:0]    m1_readdata_q, m1_readdata_d;
  logic                 m0_rdv_q, m0_rdv_d;
  logic                 m1_rdv_q, m1_rdv_d;
  logic                 rd_err_q, rd_err_d;

  logic m0_elig_s, m1_elig_s;
  logic grant_valid_s, grant_s;
  logic push_s, pop_s;

  // Arbitration: a read is only eligible while a tag slot is free.
  always_comb begin
    m0_elig_s     = m0_write | (m0_read & (count_q < MAX_CNT));
    m1_elig_s     = m1_write | (m1_read & (count_q < MAX_CNT));
    grant_valid_s = (state_q == S_IDLE) & (m0_elig_s | m1_elig_s);
    if (m0_elig_s && m1_elig_s) begin
      grant_s = ~last_grant_q;
    end else if (m0_elig_s) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
  end

  assign m0_waitrequest = ~(grant_valid_s & (grant_s == 1'b0));
  assign m1_waitrequest = ~(grant_valid_s & (grant_s == 1'b1));

  // Next-state: FSM, command register, tag FIFO and read-return steering.
  always_comb begin
    state_d          = state_q;
    cal_fail_d       = cal_fail_q | local_cal_fail;
    last_grant_d     = last_grant_q;
    cmd_port_d       = cmd_port_q;
    avl_address_d    = avl_address_q;
    avl_writedata_d  = avl_writedata_q;
    avl_byteenable_d = avl_byteenable_q;
    avl_read_d       = avl_read_q;
    avl_write_d      = avl_write_q;
    avl_bbt_d        = 1'b0;
    tag_d            = tag_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    m0_readdata_d    = m0_readdata_q;
    m1_readdata_d    = m1_readdata_q;
    m0_rdv_d         = 1'b0;
    m1_rdv_d         = 1'b0;
    rd_err_d         = rd_err_q;
    push_s           = 1'b0;
    pop_s            = 1'b0;

    case (state_q)
      S_INIT: begin
        if (local_init_done && local_cal_success && !local_cal_fail && !cal_fail_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        if (grant_valid_s) begin
          state_d      = S_ISSUE;
          last_grant_d = grant_s;
          cmd_port_d   = grant_s;
          avl_bbt_d    = 1'b1;
          // Write takes precedence when a requester strobes both.
          if (grant_s) begin
            avl_address_d    = m1_address;
            avl_writedata_d  = m1_writedata;
            avl_byteenable_d = m1_byteenable;
            avl_write_d      = m1_write;
            avl_read_d       = ~m1_write;
          end else begin
            avl_address_d    = m0_address;
            avl_writedata_d  = m0_writedata;
            avl_byteenable_d = m0_byteenable;
            avl_write_d      = m0_write;
            avl_read_d       = ~m0_write;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (avl_waitrequest_n) begin
          state_d     = S_IDLE;
          avl_read_d  = 1'b0;
          avl_write_d = 1'b0;
          push_s      = avl_read_q;
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_INIT;
      end
    endcase

    if (avl_readdatavalid) begin
      if (count_q != {CNT_W{1'b0}}) begin
        pop_s    = 1'b1;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (tag_q[rd_ptr_q]) begin
          m1_readdata_d = avl_readdata;
          m1_rdv_d      = 1'b1;
        end else begin
          m0_readdata_d = avl_readdata;
          m0_rdv_d      = 1'b1;
        end
      end else begin
        rd_err_d = 1'b1;
      end
    end else begin
      pop_s = 1'b0;
    end

    if (push_s) begin
      tag_d[wr_ptr_q] = cmd_port_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q          <= S_INIT;
      cal_fail_q       <= 1'b0;
      last_grant_q     <= 1'b1;
      cmd_port_q       <= 1'b0;
      avl_address_q    <= {ADDR_W{1'b0}};
      avl_writedata_q  <= {DATA_W{1'b0}};
      avl_byteenable_q <= {BE_W{1'b0}};
      avl_read_q       <= 1'b0;
      avl_write_q      <= 1'b0;
      avl_bbt_q        <= 1'b0;
      tag_q            <= {MAX_OUTSTANDING{1'b0}};
      wr_ptr_q         <= {PTR_W{1'b0}};
      rd_ptr_q         <= {PTR_W{1'b0}};
      count_q          <= {CNT_W{1'b0}};
      m0_readdata_q    <= {DATA_W{1'b0}};
      m1_readdata_q    <= {DATA_W{1'b0}};
      m0_rdv_q         <= 1'b0;
      m1_rdv_q         <= 1'b0;
      rd_err_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      cal_fail_q       <= cal_fail_d;
      last_grant_q     <= last_grant_d;
      cmd_port_q       <= cmd_port_d;
      avl_address_q    <= avl_address_d;
      avl_writedata_q  <= avl_writedata_d;
      avl_byteenable_q <= avl_byteenable_d;
      avl_read_q       <= avl_read_d;
      avl_write_q      <= avl_write_d;
      avl_bbt_q        <= avl_bbt_d;
      tag_q            <= tag_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      m0_readdata_q    <= m0_readdata_d;
      m1_readdata_q    <= m1_readdata_d;
      m0_rdv_q         <= m0_rdv_d;
      m1_rdv_q         <= m1_rdv_d;
      rd_err_q         <= rd_err_d;
    end
  end

  assign avl_address            = avl_address_q;
  assign avl_writedata          = avl_writedata_q;
  assign avl_byteenable         = avl_byteenable_q;
  assign avl_read               = avl_read_q;
  assign avl_write              = avl_write_q;
  assign avl_beginbursttransfer = avl_bbt_q;
  assign avl_burstcount         = 1'b1;
  assign m0_readdata            = m0_readdata_q;
  assign m1_readdata            = m1_readdata_q;
  assign m0_readdatavalid       = m0_rdv_q;
  assign m1_readdatavalid       = m1_rdv_q;
  assign mem_ready              = (state_q == S_IDLE) | (state_q == S_ISSUE);
  assign rd_err                 = rd_err_q;

endmodule

// File: tb/tb_lpddr2_avl_arbiter.sv
// Self-checking bench for lpddr2_avl_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model (one command in flight, tag queue).
module tb_lpddr2_avl_arbiter;
  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [26:0] m0_address, m1_address, avl_address;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, avl_writedata;
  logic [3:0]  m0_byteenable, m1_byteenable, avl_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata, avl_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        avl_read, avl_write, avl_beginbursttransfer, avl_burstcount;
  logic        avl_waitrequest_n, avl_readdatavalid;
  logic        local_init_done, local_cal_success, local_cal_fail;
  logic        mem_ready, rd_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_clk = ~clk_clk;

  lpddr2_avl_arbiter dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .avl_address(avl_address), .avl_writedata(avl_writedata),
    .avl_byteenable(avl_byteenable), .avl_read(avl_read), .avl_write(avl_write),
    .avl_beginbursttransfer(avl_beginbursttransfer), .avl_burstcount(avl_burstcount),
    .avl_waitrequest_n(avl_waitrequest_n), .avl_readdatavalid(avl_readdatavalid),
    .avl_readdata(avl_readdata), .local_init_done(local_init_done),
    .local_cal_success(local_cal_success), .local_cal_fail(local_cal_fail),
    .mem_ready(mem_ready), .rd_err(rd_err)
  );

  task automatic step();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    m0_address = 27'h0; m1_address = 27'h0;
    m0_writedata = 32'h0; m1_writedata = 32'h0;
    m0_byteenable = 4'h0; m1_byteenable = 4'h0;
    avl_readdatavalid = 1'b0; avl_readdata = 32'h0;
  endtask

  task automatic bring_up();
    reset_reset = 1'b1;
    idle_inputs();
    local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b0;
    avl_waitrequest_n = 1'b1;
    step(); step();
    reset_reset = 1'b0;
    local_init_done = 1'b1; local_cal_success = 1'b1;
    step();
    n_cmp++;
    if (mem_ready !== 1'b1) begin
      n_err++; $display("FAIL bring_up_mem_ready: got %b want 1", mem_ready);
    end
  endtask

  // Drives one command on a port and returns just after the accept edge.
  task automatic do_cmd(input bit port, input bit wr, input logic [26:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    bit ok = 1'b0;
    if (port) begin
      m1_address = a; m1_writedata = d; m1_byteenable = be; m1_write = wr; m1_read = !wr;
    end else begin
      m0_address = a; m0_writedata = d; m0_byteenable = be; m0_write = wr; m0_read = !wr;
    end
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((port ? m1_waitrequest : m0_waitrequest) === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    n_cmp++;
    if (!ok) begin
      n_err++; $display("FAIL do_cmd_grant_timeout: port %0d never granted, want grant", port);
    end
    step();
    if (port) begin m1_write = 1'b0; m1_read = 1'b0; end
    else begin m0_write = 1'b0; m0_read = 1'b0; end
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    idle_inputs();
    m0_write = 1'b1; m1_read = 1'b1;
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b0;
    avl_waitrequest_n = 1'b1;
    step(); step();
    n_cmp++;
    if ({m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
         avl_read, avl_write, avl_beginbursttransfer, mem_ready, rd_err} !== 9'b110000000) begin
      n_err++;
      $display("FAIL reset_ctrl: got wr0=%b wr1=%b v0=%b v1=%b rd=%b wr=%b bbt=%b rdy=%b err=%b want 110000000",
               m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid,
               avl_read, avl_write, avl_beginbursttransfer, mem_ready, rd_err);
    end
    n_cmp++;
    if ({avl_address, avl_writedata, avl_byteenable, m0_readdata, m1_readdata} !== 127'h0) begin
      n_err++;
      $display("FAIL reset_data: got addr=%h wd=%h be=%h rd0=%h rd1=%h want all 0",
               avl_address, avl_writedata, avl_byteenable, m0_readdata, m1_readdata);
    end
    idle_inputs();
  endtask

  task automatic test_gating();
    bit seen = 1'b0;
    reset_reset = 1'b1; idle_inputs();
    local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b0;
    step(); step();
    reset_reset = 1'b0;
    local_init_done = 1'b1;
    m0_write = 1'b1; m0_address = 27'h55; m0_writedata = 32'h77; m0_byteenable = 4'hF;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (m0_waitrequest !== 1'b1 || avl_write !== 1'b0) begin
        n_err++;
        $display("FAIL gating_hold: cycle %0d waitreq=%b avl_write=%b want 1/0", i, m0_waitrequest, avl_write);
      end
    end
    local_cal_success = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      if (avl_write === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL gating_release: avl_write=%b want 1 within 2 cycles", avl_write);
    end
    m0_write = 1'b0;
    step();
  endtask

  task automatic test_cal_fail();
    reset_reset = 1'b1; idle_inputs();
    local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b0;
    step(); step();
    reset_reset = 1'b0;
    local_init_done = 1'b1; local_cal_success = 1'b1; local_cal_fail = 1'b1;
    m0_write = 1'b1;
    step();
    local_cal_fail = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_cmp++;
      if (mem_ready !== 1'b0 || m0_waitrequest !== 1'b1) begin
        n_err++;
        $display("FAIL cal_fail_sticky: cycle %0d mem_ready=%b waitreq=%b want 0/1", i, mem_ready, m0_waitrequest);
      end
    end
    m0_write = 1'b0;
  endtask

  task automatic test_single_write();
    bring_up();
    do_cmd(1'b0, 1'b1, 27'h1234567, 32'hDEADBEEF, 4'hF);
    n_cmp++;
    if (avl_write !== 1'b1 || avl_read !== 1'b0 || avl_address !== 27'h1234567 ||
        avl_writedata !== 32'hDEADBEEF || avl_byteenable !== 4'hF ||
        avl_beginbursttransfer !== 1'b1 || avl_burstcount !== 1'b1) begin
      n_err++;
      $display("FAIL single_write: wr=%b rd=%b addr=%h wd=%h be=%h bbt=%b bc=%b want 1 0 1234567 deadbeef f 1 1",
               avl_write, avl_read, avl_address, avl_writedata, avl_byteenable,
               avl_beginbursttransfer, avl_burstcount);
    end
    step();
    n_cmp++;
    if (avl_write !== 1'b0 || avl_beginbursttransfer !== 1'b0) begin
      n_err++; $display("FAIL single_write_len: wr=%b bbt=%b want 0 0", avl_write, avl_beginbursttransfer);
    end
  endtask

  task automatic test_fairness();
    bit exp_port = 1'b0;
    int got = 0;
    bring_up();
    m0_write = 1'b1; m0_address = 27'h100; m0_writedata = 32'hA0; m0_byteenable = 4'hF;
    m1_write = 1'b1; m1_address = 27'h200; m1_writedata = 32'hB1; m1_byteenable = 4'hF;
    for (int i = 0; i < 40 && got < 8; i++) begin
      step();
      if (avl_write === 1'b1) begin
        n_cmp++;
        if (avl_address !== (exp_port ? 27'h200 : 27'h100)) begin
          n_err++; $display("FAIL fairness_order: grant %0d addr=%h want port %0d", got, avl_address, exp_port);
        end
        exp_port = ~exp_port;
        got++;
      end
    end
    n_cmp++;
    if (got != 8) begin
      n_err++; $display("FAIL fairness_count: got %0d writes want 8", got);
    end
    idle_inputs();
    step();
  endtask

  task automatic test_routing();
    bit exp_port [3] = '{1'b0, 1'b1, 1'b0};
    bring_up();
    do_cmd(1'b0, 1'b0, 27'h0A, 32'h0, 4'hF);
    do_cmd(1'b1, 1'b0, 27'h0B, 32'h0, 4'hF);
    do_cmd(1'b0, 1'b0, 27'h0C, 32'h0, 4'hF);
    for (int k = 0; k < 3; k++) begin
      avl_readdatavalid = 1'b1; avl_readdata = 32'(k + 1);
      step();
      avl_readdatavalid = 1'b0;
      n_cmp++;
      if (exp_port[k] ? (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'(k + 1) || m0_readdatavalid !== 1'b0)
                      : (m0_readdatavalid !== 1'b1 || m0_readdata !== 32'(k + 1) || m1_readdatavalid !== 1'b0)) begin
        n_err++;
        $display("FAIL routing_ret%0d: v0=%b d0=%h v1=%b d1=%h want port %0d data %0d",
                 k, m0_readdatavalid, m0_readdata, m1_readdatavalid, m1_readdata, exp_port[k], k + 1);
      end
    end
    step();
    n_cmp++;
    if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 ||
        m0_readdata !== 32'h3 || m1_readdata !== 32'h2) begin
      n_err++;
      $display("FAIL routing_hold: v0=%b v1=%b d0=%h d1=%h want 0 0 3 2",
               m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata);
    end
  endtask

  task automatic test_backpressure();
    bring_up();
    avl_waitrequest_n = 1'b0;
    do_cmd(1'b0, 1'b1, 27'h0ABCDEF, 32'h12345678, 4'h5);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (avl_write !== 1'b1 || avl_address !== 27'h0ABCDEF || avl_writedata !== 32'h12345678 ||
          avl_byteenable !== 4'h5 || avl_beginbursttransfer !== (i == 0)) begin
        n_err++;
        $display("FAIL backpressure_stable: cycle %0d wr=%b addr=%h wd=%h be=%h bbt=%b want 1 0abcdef 12345678 5 %0d",
                 i, avl_write, avl_address, avl_writedata, avl_byteenable, avl_beginbursttransfer, i == 0);
      end
      step();
    end
    avl_waitrequest_n = 1'b1;
    n_cmp++;
    if (avl_write !== 1'b1 || avl_beginbursttransfer !== 1'b0) begin
      n_err++; $display("FAIL backpressure_last: wr=%b bbt=%b want 1 0", avl_write, avl_beginbursttransfer);
    end
    step();
    n_cmp++;
    if (avl_write !== 1'b0 || mem_ready !== 1'b1) begin
      n_err++; $display("FAIL backpressure_done: wr=%b rdy=%b want 0 1", avl_write, mem_ready);
    end
  endtask

  task automatic test_full();
    bring_up();
    for (int i = 0; i < 8; i++) do_cmd(1'b1, 1'b0, 27'(i), 32'h0, 4'hF);
    step();
    m1_read = 1'b1; m1_address = 27'h99;
    m0_write = 1'b1; m0_address = 27'h44; m0_writedata = 32'h4444; m0_byteenable = 4'hF;
    #1;
    n_cmp++;
    if (m1_waitrequest !== 1'b1 || m0_waitrequest !== 1'b0) begin
      n_err++; $display("FAIL full_stall: wr1=%b wr0=%b want 1 0", m1_waitrequest, m0_waitrequest);
    end
    step();
    m0_write = 1'b0;
    n_cmp++;
    if (avl_write !== 1'b1 || avl_address !== 27'h44) begin
      n_err++; $display("FAIL full_write_issue: wr=%b addr=%h want 1 44", avl_write, avl_address);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (m1_waitrequest !== 1'b1) begin
        n_err++; $display("FAIL full_hold: cycle %0d wr1=%b want 1", i, m1_waitrequest);
      end
      step();
    end
    avl_readdatavalid = 1'b1; avl_readdata = 32'hCAFE;
    step();
    avl_readdatavalid = 1'b0;
    n_cmp++;
    if (m1_readdatavalid !== 1'b1 || m1_readdata !== 32'hCAFE || m1_waitrequest !== 1'b0) begin
      n_err++;
      $display("FAIL full_unblock: v1=%b d1=%h wr1=%b want 1 cafe 0", m1_readdatavalid, m1_readdata, m1_waitrequest);
    end
    step();
    m1_read = 1'b0;
    n_cmp++;
    if (avl_read !== 1'b1 || avl_address !== 27'h99) begin
      n_err++; $display("FAIL full_ninth: rd=%b addr=%h want 1 99", avl_read, avl_address);
    end
  endtask

  task automatic test_errors();
    bring_up();
    avl_readdatavalid = 1'b1; avl_readdata = 32'h5A5A;
    step();
    avl_readdatavalid = 1'b0;
    n_cmp++;
    if (rd_err !== 1'b1 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      n_err++; $display("FAIL rd_err_set: err=%b v0=%b v1=%b want 1 0 0", rd_err, m0_readdatavalid, m1_readdatavalid);
    end
    for (int i = 0; i < 5; i++) step();
    n_cmp++;
    if (rd_err !== 1'b1 || m0_readdata !== 32'h0) begin
      n_err++; $display("FAIL rd_err_sticky: err=%b d0=%h want 1 0", rd_err, m0_readdata);
    end
    reset_reset = 1'b1;
    step();
    reset_reset = 1'b0;
    n_cmp++;
    if (rd_err !== 1'b0) begin
      n_err++; $display("FAIL rd_err_clear: err=%b want 0", rd_err);
    end
  endtask

  task automatic test_reset_in_issue();
    bring_up();
    avl_waitrequest_n = 1'b0;
    do_cmd(1'b0, 1'b0, 27'h321, 32'h0, 4'hF);
    n_cmp++;
    if (avl_read !== 1'b1) begin
      n_err++; $display("FAIL issue_before_reset: rd=%b want 1", avl_read);
    end
    reset_reset = 1'b1;
    step();
    n_cmp++;
    if (avl_read !== 1'b0 || mem_ready !== 1'b0 || m0_waitrequest !== 1'b1 || avl_address !== 27'h0) begin
      n_err++;
      $display("FAIL reset_in_issue: rd=%b rdy=%b wr0=%b addr=%h want 0 0 1 0", avl_read, mem_ready, m0_waitrequest, avl_address);
    end
    reset_reset = 1'b0;
    avl_waitrequest_n = 1'b1;
  endtask

  // Randomized traffic against a transaction model: at most one command in flight,
  // grants follow round-robin over eligible ports, reads return in issue order.
  task automatic test_random();
    bit          tags [$];
    bit          pending = 1'b0, first = 1'b0, last = 1'b1;
    bit          cur_wr = 1'b0, cur_port = 1'b0;
    logic [26:0] cur_a = 27'h0;
    logic [31:0] cur_d = 32'h0;
    logic [3:0]  cur_be = 4'h0;
    bit          ev0 = 1'b0, ev1 = 1'b0;
    logic [31:0] hd0 = 32'h0, hd1 = 32'h0;
    int          returns = 0;
    bring_up();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit e0, e1, any, g, ew0, ew1, t;
      int r0 = $urandom_range(0, 4);
      int r1 = $urandom_range(0, 4);
      m0_read = (r0 == 1 || r0 == 3); m0_write = (r0 == 2 || r0 == 3);
      m1_read = (r1 == 1 || r1 == 3); m1_write = (r1 == 2 || r1 == 3);
      m0_address = 27'($urandom()); m1_address = 27'($urandom());
      m0_writedata = $urandom(); m1_writedata = $urandom();
      m0_byteenable = 4'($urandom()); m1_byteenable = 4'($urandom());
      avl_waitrequest_n = ($urandom_range(0, 2) != 0);
      avl_readdatavalid = (tags.size() > 0) && ($urandom_range(0, 5) == 0);
      avl_readdata = $urandom();
      #1;
      n_cmp++;
      if (m0_readdatavalid !== ev0 || m1_readdatavalid !== ev1 ||
          m0_readdata !== hd0 || m1_readdata !== hd1) begin
        n_err++;
        $display("FAIL rand_return c%0d: v0=%b d0=%h v1=%b d1=%h want %b %h %b %h",
                 cyc, m0_readdatavalid, m0_readdata, m1_readdatavalid, m1_readdata, ev0, hd0, ev1, hd1);
      end
      e0 = m0_write || (m0_read && tags.size() < 8);
      e1 = m1_write || (m1_read && tags.size() < 8);
      any = !pending && (e0 || e1);
      g = (e0 && e1) ? !last : !e0;
      ew0 = !(any && g == 1'b0);
      ew1 = !(any && g == 1'b1);
      n_cmp++;
      if (m0_waitrequest !== ew0 || m1_waitrequest !== ew1) begin
        n_err++;
        $display("FAIL rand_grant c%0d: wr0=%b wr1=%b want %b %b", cyc, m0_waitrequest, m1_waitrequest, ew0, ew1);
      end
      n_cmp++;
      if (pending) begin
        if (avl_write !== cur_wr || avl_read !== !cur_wr || avl_address !== cur_a ||
            avl_writedata !== cur_d || avl_byteenable !== cur_be || avl_beginbursttransfer !== first) begin
          n_err++;
          $display("FAIL rand_issue c%0d: wr=%b rd=%b addr=%h wd=%h be=%h bbt=%b want wr=%b %h %h %h bbt=%b",
                   cyc, avl_write, avl_read, avl_address, avl_writedata, avl_byteenable,
                   avl_beginbursttransfer, cur_wr, cur_a, cur_d, cur_be, first);
        end
      end else if (avl_write !== 1'b0 || avl_read !== 1'b0) begin
        n_err++; $display("FAIL rand_idle c%0d: wr=%b rd=%b want 0 0", cyc, avl_write, avl_read);
      end
      ev0 = 1'b0; ev1 = 1'b0;
      if (avl_readdatavalid) begin
        t = tags.pop_front();
        returns++;
        if (t) begin ev1 = 1'b1; hd1 = avl_readdata; end
        else begin ev0 = 1'b1; hd0 = avl_readdata; end
      end
      if (pending && avl_waitrequest_n) begin
        pending = 1'b0;
        if (!cur_wr) tags.push_back(cur_port);
      end else if (any) begin
        pending = 1'b1; first = 1'b1; last = g; cur_port = g;
        cur_wr = g ? m1_write : m0_write;
        cur_a  = g ? m1_address : m0_address;
        cur_d  = g ? m1_writedata : m0_writedata;
        cur_be = g ? m1_byteenable : m0_byteenable;
      end else begin
        first = 1'b0;
      end
      step();
    end
    idle_inputs();
    n_cmp++;
    if (returns == 0) begin
      n_err++; $display("FAIL rand_activity: got %0d returns want >0", returns);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_reset = 1'b1;
    idle_inputs();
    local_init_done = 1'b0; local_cal_success = 1'b0; local_cal_fail = 1'b0;
    avl_waitrequest_n = 1'b1;
    test_reset();
    test_gating();
    test_cal_fail();
    test_single_write();
    test_fairness();
    test_routing();
    test_backpressure();
    test_full();
    test_errors();
    test_reset_in_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
